// File: rtl/capture_ctrl_pkg.sv
// Shared definitions for the waveform capture controller.
//   state_e  : capture state machine encoding (idle, armed, capturing, holding)
//   DefDepth : default samples per capture (display width in pixels)
//   DefH     : default display height in pixels
package capture_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2,
        StHold    = 2'd3
    } state_e;

    localparam int unsigned DefDepth = 100;
    localparam int unsigned DefH     = 100;

endpackage

// File: rtl/trig_detect.sv
// Edge trigger detector: remembers the previously accepted sample and flags a
// threshold crossing on the current accepted sample.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   clr           : invalidate the remembered sample (re-arm)
//   sample_valid  : sample strobe
//   sample        : current sample
//   trig_level    : threshold
//   trig_rising   : 1 = rising crossing, 0 = falling crossing
//   hit           : combinational, current accepted sample crosses the threshold
module trig_detect #(
    parameter int unsigned SAMPLE_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [SAMPLE_W-1:0] trig_level,
    input  logic                trig_rising,
    output logic                hit
);

    logic [SAMPLE_W-1:0] prev_q;
    logic                prev_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            if (sample_valid) begin
                prev_q <= sample;
            end
            // A sample taken on the re-arm edge belongs to the old session and
            // must not serve as the reference for the new one.
            if (clr) begin
                prev_valid_q <= 1'b0;
            end else if (sample_valid) begin
                prev_valid_q <= 1'b1;
            end
        end
    end

    always_comb begin
        hit = 1'b0;
        if (sample_valid && prev_valid_q) begin
            if (trig_rising) begin
                hit = (prev_q < trig_level) && (sample >= trig_level);
            end else begin
                hit = (prev_q > trig_level) && (sample <= trig_level);
            end
        end
    end

endmodule

// File: rtl/capture_ctrl.sv
// Oscilloscope-style capture controller. Waits for a trigger on the sample
// stream, writes DEPTH scaled samples into the back half of a double-buffered
// waveform RAM, then swaps buffers on the next vertical blank.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   sample_valid      : sample strobe
//   sample            : unsigned ADC sample
//   trig_level        : trigger threshold
//   trig_rising       : 1 = rising-edge trigger, 0 = falling-edge trigger
//   auto_mode         : re-arm after each swap, force a trigger on timeout
//   arm               : single-shot arm pulse (only honoured when idle)
//   frame_start       : one-cycle pulse at start of vertical blank
//   wr_en/buf/addr/data : registered RAM write port (1-cycle latency)
//   disp_buf          : buffer currently shown by the display
//   busy              : controller not idle
//   done              : one-cycle pulse on buffer swap
module capture_ctrl
    import capture_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH    = DefDepth,
    parameter int unsigned H        = DefH,
    parameter int unsigned SAMPLE_W = 8,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned TIMEOUT  = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [SAMPLE_W-1:0] trig_level,
    input  logic                trig_rising,
    input  logic                auto_mode,
    input  logic                arm,
    input  logic                frame_start,
    output logic                wr_en,
    output logic                wr_buf,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic                disp_buf,
    output logic                busy,
    output logic                done
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);
    localparam logic [CntW-1:0]   LastCnt = CntW'(TIMEOUT - 1);

    state_e              state_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [CntW-1:0]     tmo_q;
    logic                wr_en_q;
    logic                wr_buf_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic                disp_buf_q;
    logic                done_q;

    logic                hit;
    logic                tmo_hit;
    logic                trigger;
    logic                swap;
    logic                enter_armed;
    logic [31:0]         sample_ext;
    logic [DATA_W-1:0]   scaled;

    trig_detect #(
        .SAMPLE_W (SAMPLE_W)
    ) u_trig_detect (
        .clk          (clk),
        .reset        (reset),
        .clr          (enter_armed),
        .sample_valid (sample_valid),
        .sample       (sample),
        .trig_level   (trig_level),
        .trig_rising  (trig_rising),
        .hit          (hit)
    );

    // Row index counted from the top: sample 0 lands on the bottom row H.
    always_comb begin
        sample_ext = 32'(sample);
        if (sample_ext >= 32'(H)) begin
            scaled = '0;
        end else begin
            scaled = DATA_W'(32'(H) - sample_ext);
        end
    end

    assign tmo_hit = auto_mode && (tmo_q == LastCnt);
    assign trigger = (state_q == StArmed) && sample_valid && (hit || tmo_hit);
    // wr_en_q is high only in the first HOLD cycle (the final write), so a
    // frame_start coincident with that write is ignored.
    assign swap    = (state_q == StHold) && frame_start && !wr_en_q;

    always_comb begin
        enter_armed = 1'b0;
        case (state_q)
            StIdle:  enter_armed = arm | auto_mode;
            StHold:  enter_armed = swap & auto_mode;
            default: enter_armed = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            tmo_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_buf_q   <= 1'b1;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            disp_buf_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (enter_armed) begin
                        state_q <= StArmed;
                        tmo_q   <= '0;
                    end
                end
                StArmed: begin
                    if (trigger) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= '0;
                        wr_data_q <= scaled;
                        idx_q     <= ADDR_W'(1);
                        state_q   <= (LastIdx == '0) ? StHold : StCapture;
                    end else if (sample_valid && auto_mode) begin
                        tmo_q <= tmo_q + CntW'(1);
                    end
                end
                StCapture: begin
                    if (sample_valid) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= idx_q;
                        wr_data_q <= scaled;
                        if (idx_q == LastIdx) begin
                            state_q <= StHold;
                        end else begin
                            idx_q <= idx_q + ADDR_W'(1);
                        end
                    end
                end
                StHold: begin
                    if (swap) begin
                        disp_buf_q <= ~disp_buf_q;
                        wr_buf_q   <= disp_buf_q;  // keeps wr_buf == ~disp_buf
                        done_q     <= 1'b1;
                        if (enter_armed) begin
                            state_q <= StArmed;
                            tmo_q   <= '0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_buf   = wr_buf_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign disp_buf = disp_buf_q;
    assign done     = done_q;
    assign busy     = (state_q != StIdle);

endmodule
